mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage data-access controller. Consumes the load/store request held in the EX/MEM pipeline register and runs it on the data bus as a request/grant/response transaction. It generates byte enables and replicated store data, formats and sign/zero-extends load data, and stalls the pipeline until the access completes. It sits between the EX/MEM stage register and the data-memory port, and acts as the responder end of the memory-operation path that the EX/MEM stage register feeds.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, bus/data width; only 32 is supported.
- `MAX_WAIT`, 255, cycles allowed in REQ+WAIT before bus error; minimum 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `EXMEM_StType`  in  `ST_TYPE_WIDTH`  store type: 0 none, 1 SB, 2 SH, 3 SW.
- `EXMEM_LdType`  in  `LD_TYPE_WIDTH`  load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- `EXMEM_Addr`  in  ADDR_WIDTH  byte address.
- `EXMEM_StData`  in  DATA_WIDTH  store source register value.
- `ExtStall`  in  1  stall from a later stage; holds the DONE state.
- `MemStall`  out  1  hold IF..EX/MEM.
- `LdData`  out  DATA_WIDTH  formatted load result.
- `LdValid`  out  1  LdData is valid this cycle.
- `MisalignExc`  out  1  misaligned access; no bus activity.
- `BusErr`  out  1  one-cycle pulse on timeout.
- `DBus_Req`  out  1  bus request.
- `DBus_We`  out  1  1 = write.
- `DBus_Addr`  out  ADDR_WIDTH  word address; bits [1:0] are 0.
- `DBus_BE`  out  4  byte enables.
- `DBus_WData`  out  DATA_WIDTH  write data.
- `DBus_Gnt`  in  1  request accepted.
- `DBus_RValid`  in  1  response; write ack or read data.
- `DBus_RData`  in  DATA_WIDTH  read data.

## Operation
- Op present: `|{EXMEM_StType, EXMEM_LdType}`. If both fields are nonzero, the store wins.
- Misaligned:
  - SH, LH or LHU with Addr[0]=1.
  - SW or LW with Addr[1:0]≠0.
  - In IDLE this sets `MisalignExc`=1 combinationally. No request is issued, no stall, and the FSM stays in IDLE.
- Byte enables and write data:
  - SB: BE=1<<Addr[1:0], WData={4{StData[7:0]}}.
  - SH: BE=Addr[1]?4'b1100:4'b0011, WData={2{StData[15:0]}}.
  - SW: BE=4'b1111.
  - Loads use the same BE pattern as the store of the same size.
- Load format: shift RData right by 8*Addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. The result is captured into `LdData` on the RValid cycle.
- FSM states:
  - IDLE: on an aligned op, go to REQ and register the bus fields.
  - REQ: `DBus_Req`=1 with all bus fields stable. On Gnt=1, go to WAIT.
  - WAIT: `DBus_Req`=0. On RValid=1, go to DONE.
  - DONE: `LdValid`=1 for loads. If ExtStall=1, stay in DONE; otherwise return to IDLE.
- `MemStall` = (IDLE & aligned op) | REQ | WAIT.
- Timeout counter:
  - Cleared on IDLE→REQ; increments in REQ and WAIT.
  - When it reaches MAX_WAIT-1: pulse `BusErr`, set LdData=0, go to DONE.
  - A late Gnt or RValid arriving afterwards is ignored.
- Reset values: state IDLE, all outputs 0, LdData 0, counter 0.
- Reset mid-transaction: FSM returns to IDLE and Req drops the next cycle. The outstanding bus response is dropped.

## Timing
- Minimum latency, with Gnt in the first REQ cycle and RValid one cycle later:
  - c0: IDLE, stall.
  - c1: REQ, stall.
  - c2: WAIT with RValid, stall.
  - c3: DONE, no stall, LdValid.
- The pipeline advances at the end of c3, so the next op is evaluated at c4.
- Gnt and RValid asserted in the same REQ cycle: take REQ→WAIT only; RValid in REQ is not legal bus behaviour.
- Back-to-back ops: each op costs ≥4 cycles. The FSM does not re-issue an op, because DONE always passes through IDLE only after the EX/MEM register has advanced.

## Structure
- Define.v holds:
  - `ST_TYPE_WIDTH`=2 and `LD_TYPE_WIDTH`=3.
  - The St/Ld encodings as `define constants.
  - The state encodings.
- One sub-module, `load_formatter`: combinational shift plus sign/zero-extension, reused by the verification model.

## Test plan
- LW, Addr=0x100, memory word 0xDEADBEEF, Gnt same cycle, RValid next: Req in c1, LdData=0xDEADBEEF with LdValid in c3, MemStall high c0–c2.
- LB, Addr=0x103, RData=0x80FFFFFF: LdData=0xFFFFFF80. LBU at the same address: LdData=0x00000080.
- SH, Addr=0x202, StData=0x1234ABCD: BE=4'b1100, WData=0xABCDABCD, DBus_Addr=0x200, DBus_We=1.
- LW at Addr=0x101: MisalignExc=1, MemStall=0, DBus_Req never asserted.
- Gnt held low with MAX_WAIT=4: BusErr pulse at the 4th REQ cycle, then DONE with LdData=0.
- rst asserted while in WAIT: IDLE next cycle, all outputs 0, a subsequent RValid is ignored.
- ExtStall=1 for 3 cycles in DONE: LdData and LdValid held for all 3 cycles, no new request issued.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_access_ctrl_pkg
//  Description : Load/store type encodings, FSM states and byte-lane helpers
//                shared by the memory-stage data-access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  localparam int ST_TYPE_WIDTH = 2;
  localparam int LD_TYPE_WIDTH = 3;

  // Store type encodings
  localparam logic [ST_TYPE_WIDTH-1:0] ST_NONE = 2'd0;
  localparam logic [ST_TYPE_WIDTH-1:0] ST_SB   = 2'd1;
  localparam logic [ST_TYPE_WIDTH-1:0] ST_SH   = 2'd2;
  localparam logic [ST_TYPE_WIDTH-1:0] ST_SW   = 2'd3;

  // Load type encodings
  localparam logic [LD_TYPE_WIDTH-1:0] LD_NONE = 3'd0;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LB   = 3'd1;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LH   = 3'd2;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LW   = 3'd3;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LBU  = 3'd4;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LHU  = 3'd5;

  // Bus transaction states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Access size derived from the op fields
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // A store in the stage register takes precedence over a load.
  function automatic size_e access_size(input logic [ST_TYPE_WIDTH-1:0] st,
                                        input logic [LD_TYPE_WIDTH-1:0] ld);
    size_e sz;
    sz = SZ_WORD;
    if (st != ST_NONE) begin
      case (st)
        ST_SB:   sz = SZ_BYTE;
        ST_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ld)
        LD_LB, LD_LBU: sz = SZ_BYTE;
        LD_LH, LD_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    logic mis;
    case (sz)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input size_e sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : load_formatter
//  Description : Aligns the addressed bytes of a 32-bit read word down to
//                bit 0 and sign- or zero-extends them per load type.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0]              i_rdata,
  input  logic [LD_TYPE_WIDTH-1:0] i_ld_type,
  input  logic [1:0]               i_addr_lo,
  output logic [31:0]              o_ld_data
);

  logic [31:0] w_shifted;

  // Shift the addressed lane down, then extend to full width
  always_comb begin
    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    case (i_ld_type)
      LD_LB:   o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LD_LH:   o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LD_LBU:  o_ld_data = {24'd0, w_shifted[7:0]};
      LD_LHU:  o_ld_data = {16'd0, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Memory-stage data-access controller. Runs the EX/MEM
//                load/store as a req/gnt/rvalid bus transaction, builds byte
//                enables and replicated store data, formats load data and
//                stalls the pipeline until the access completes.
//                Only DATA_WIDTH = 32 is supported; MAX_WAIT must be >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ST_TYPE_WIDTH-1:0] EXMEM_StType,
  input  logic [LD_TYPE_WIDTH-1:0] EXMEM_LdType,
  input  logic [ADDR_WIDTH-1:0]    EXMEM_Addr,
  input  logic [DATA_WIDTH-1:0]    EXMEM_StData,
  input  logic                     ExtStall,
  output logic                     MemStall,
  output logic [DATA_WIDTH-1:0]    LdData,
  output logic                     LdValid,
  output logic                     MisalignExc,
  output logic                     BusErr,
  output logic                     DBus_Req,
  output logic                     DBus_We,
  output logic [ADDR_WIDTH-1:0]    DBus_Addr,
  output logic [3:0]               DBus_BE,
  output logic [DATA_WIDTH-1:0]    DBus_WData,
  input  logic                     DBus_Gnt,
  input  logic                     DBus_RValid,
  input  logic [DATA_WIDTH-1:0]    DBus_RData
);

  localparam int               CNT_W    = $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [3:0]               be_q, be_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     is_load_q, is_load_d;
  logic [LD_TYPE_WIDTH-1:0] ld_type_q, ld_type_d;
  logic [1:0]               addr_lo_q, addr_lo_d;
  logic [DATA_WIDTH-1:0]    ld_data_q, ld_data_d;

  logic                     w_is_store;
  logic                     w_op;
  size_e                    w_size;
  logic                     w_misaligned;
  logic                     w_aligned_op;
  logic                     w_busy;
  logic                     w_timeout;
  logic [DATA_WIDTH-1:0]    w_fmt_data;

  // Lane alignment and extension of the returning read word
  load_formatter u_load_formatter (
    .i_rdata   (DBus_RData),
    .i_ld_type (ld_type_q),
    .i_addr_lo (addr_lo_q),
    .o_ld_data (w_fmt_data)
  );

  // Decode the stage-register op and the timeout condition
  always_comb begin
    w_is_store   = (EXMEM_StType != ST_NONE);
    w_op         = |{EXMEM_StType, EXMEM_LdType};
    w_size       = access_size(EXMEM_StType, EXMEM_LdType);
    w_misaligned = w_op & is_misaligned(w_size, EXMEM_Addr[1:0]);
    w_aligned_op = w_op & ~w_misaligned;
    w_busy       = (state_q == S_REQ) || (state_q == S_WAIT);
    // Timeout has priority over a Gnt/RValid arriving in the same cycle
    w_timeout    = w_busy && (cnt_q == CNT_LAST);
  end

  // Next-state and next-register computation for the bus transaction
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    is_load_d = is_load_q;
    ld_type_d = ld_type_q;
    addr_lo_d = addr_lo_q;
    ld_data_d = ld_data_q;

    case (state_q)
      S_IDLE: begin
        if (w_aligned_op) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          we_d      = w_is_store;
          addr_d    = {EXMEM_Addr[ADDR_WIDTH-1:2], 2'b00};
          be_d      = byte_enables(w_size, EXMEM_Addr[1:0]);
          is_load_d = ~w_is_store;
          ld_type_d = EXMEM_LdType;
          addr_lo_d = EXMEM_Addr[1:0];
          if (!w_is_store) begin
            wdata_d = '0;
          end else begin
            case (w_size)
              SZ_BYTE: wdata_d = {4{EXMEM_StData[7:0]}};
              SZ_HALF: wdata_d = {2{EXMEM_StData[15:0]}};
              default: wdata_d = EXMEM_StData;
            endcase
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (w_timeout) begin
          state_d   = S_DONE;
          ld_data_d = '0;
        end else if (DBus_Gnt) begin
          // A same-cycle RValid is not legal here and is ignored
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (w_timeout) begin
          state_d   = S_DONE;
          ld_data_d = '0;
        end else if (DBus_RValid) begin
          state_d = S_DONE;
          if (is_load_q) begin
            ld_data_d = w_fmt_data;
          end
        end
      end
      default: begin
        // Leave DONE only once the later stage releases the pipeline
        if (!ExtStall) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      is_load_q <= 1'b0;
      ld_type_q <= LD_NONE;
      addr_lo_q <= 2'b00;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      is_load_q <= is_load_d;
      ld_type_q <= ld_type_d;
      addr_lo_q <= addr_lo_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Output decode: bus fields come straight from registers
  always_comb begin
    MemStall    = ((state_q == S_IDLE) && w_aligned_op) || w_busy;
    MisalignExc = (state_q == S_IDLE) && w_misaligned;
    BusErr      = w_timeout;
    LdValid     = (state_q == S_DONE) && is_load_q;
    LdData      = ld_data_q;
    DBus_Req    = (state_q == S_REQ);
    DBus_We     = we_q;
    DBus_Addr   = addr_q;
    DBus_BE     = be_q;
    DBus_WData  = wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed self-checking bench for mem_access_ctrl with a
//                scoreboard of expected bus requests and load results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk;
  logic        rst;
  logic [1:0]  StType;
  logic [2:0]  LdType;
  logic [31:0] Addr;
  logic [31:0] StData;
  logic        ExtStall;
  logic        MemStall;
  logic [31:0] LdData;
  logic        LdValid;
  logic        MisalignExc;
  logic        BusErr;
  logic        DBus_Req;
  logic        DBus_We;
  logic [31:0] DBus_Addr;
  logic [3:0]  DBus_BE;
  logic [31:0] DBus_WData;
  logic        DBus_Gnt;
  logic        DBus_RValid;
  logic [31:0] DBus_RData;

  int n_checks = 0;
  int n_errors = 0;

  bus_t        exp_bus[$];
  logic [31:0] exp_ld[$];

  mem_access_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_WAIT   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .EXMEM_StType (StType),
    .EXMEM_LdType (LdType),
    .EXMEM_Addr   (Addr),
    .EXMEM_StData (StData),
    .ExtStall     (ExtStall),
    .MemStall     (MemStall),
    .LdData       (LdData),
    .LdValid      (LdValid),
    .MisalignExc  (MisalignExc),
    .BusErr       (BusErr),
    .DBus_Req     (DBus_Req),
    .DBus_We      (DBus_We),
    .DBus_Addr    (DBus_Addr),
    .DBus_BE      (DBus_BE),
    .DBus_WData   (DBus_WData),
    .DBus_Gnt     (DBus_Gnt),
    .DBus_RValid  (DBus_RValid),
    .DBus_RData   (DBus_RData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tname);
    check({tname, "/MemStall"},    MemStall,    0);
    check({tname, "/LdData"},      LdData,      0);
    check({tname, "/LdValid"},     LdValid,     0);
    check({tname, "/MisalignExc"}, MisalignExc, 0);
    check({tname, "/BusErr"},      BusErr,      0);
    check({tname, "/DBus_Req"},    DBus_Req,    0);
    check({tname, "/DBus_We"},     DBus_We,     0);
    check({tname, "/DBus_Addr"},   DBus_Addr,   0);
    check({tname, "/DBus_BE"},     DBus_BE,     0);
    check({tname, "/DBus_WData"},  DBus_WData,  0);
  endtask

  task automatic clear_op();
    StType = 2'd0;
    LdType = 3'd0;
    Addr   = 32'h0;
    StData = 32'h0;
  endtask

  // One full access: Gnt on the first Req cycle, RValid the cycle after.
  task automatic do_access(input string tname, input logic [1:0] st, input logic [2:0] ld,
                           input logic [31:0] addr, input logic [31:0] stdata,
                           input logic [31:0] rdata, input bus_t eb,
                           input logic [31:0] eld, input int ext_cycles);
    bus_t        ob;
    logic [31:0] el;
    bit          got;
    bit          is_ld;
    is_ld = (st == 2'd0);
    el    = 32'h0;
    exp_bus.push_back(eb);
    if (is_ld) exp_ld.push_back(eld);

    @(posedge clk); #1;
    StType = st; LdType = ld; Addr = addr; StData = stdata;
    #2;
    check({tname, "/c0_stall"}, MemStall, 1);
    check({tname, "/c0_req"},   DBus_Req, 0);

    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #3;
      if (DBus_Req) got = 1'b1;
    end
    check({tname, "/req_seen"}, got, 1);
    if (got) begin
      ob = exp_bus.pop_front();
      check({tname, "/we"},    DBus_We,   ob.we);
      check({tname, "/addr"},  DBus_Addr, ob.addr);
      check({tname, "/be"},    DBus_BE,   ob.be);
      if (ob.we) check({tname, "/wdata"}, DBus_WData, ob.wdata);
      check({tname, "/req_stall"}, MemStall, 1);
      DBus_Gnt = 1'b1;
    end

    @(posedge clk); #1;
    DBus_Gnt = 1'b0; DBus_RValid = 1'b1; DBus_RData = rdata;
    #2;
    check({tname, "/wait_stall"}, MemStall, 1);
    check({tname, "/wait_req"},   DBus_Req, 0);

    @(posedge clk); #1;
    DBus_RValid = 1'b0; ExtStall = (ext_cycles > 0);
    #2;
    check({tname, "/done_ldvalid"}, LdValid,  is_ld);
    check({tname, "/done_stall"},   MemStall, 0);
    if (is_ld) begin
      el = exp_ld.pop_front();
      check({tname, "/ld_data"}, LdData, el);
    end

    for (int j = 1; j <= ext_cycles; j++) begin
      @(posedge clk); #1;
      if (j == ext_cycles) ExtStall = 1'b0;
      #2;
      check({tname, "/hold_ldvalid"}, LdValid, is_ld);
      if (is_ld) check({tname, "/hold_lddata"}, LdData, el);
      check({tname, "/hold_req"}, DBus_Req, 0);
    end

    @(posedge clk); #1;
    clear_op();
  endtask

  initial begin
    rst = 1'b1; ExtStall = 1'b0;
    DBus_Gnt = 1'b0; DBus_RValid = 1'b0; DBus_RData = 32'h0;
    clear_op();

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Loads and stores of every size
    do_access("lw",   2'd0, 3'd3, 32'h100, 32'h0, 32'hDEADBEEF,
              '{1'b0, 32'h100, 4'b1111, 32'h0}, 32'hDEADBEEF, 0);
    do_access("lb",   2'd0, 3'd1, 32'h103, 32'h0, 32'h80FFFFFF,
              '{1'b0, 32'h100, 4'b1000, 32'h0}, 32'hFFFFFF80, 0);
    do_access("lbu",  2'd0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF,
              '{1'b0, 32'h100, 4'b1000, 32'h0}, 32'h00000080, 0);
    do_access("lb_pos", 2'd0, 3'd1, 32'h101, 32'h0, 32'h00007F00,
              '{1'b0, 32'h100, 4'b0010, 32'h0}, 32'h0000007F, 0);
    do_access("lh",   2'd0, 3'd2, 32'h102, 32'h0, 32'h80011234,
              '{1'b0, 32'h100, 4'b1100, 32'h0}, 32'hFFFF8001, 0);
    do_access("lhu",  2'd0, 3'd5, 32'h000, 32'h0, 32'h80019234,
              '{1'b0, 32'h000, 4'b0011, 32'h0}, 32'h00009234, 0);
    do_access("sh",   2'd2, 3'd0, 32'h202, 32'h1234ABCD, 32'h0,
              '{1'b1, 32'h200, 4'b1100, 32'hABCDABCD}, 32'h0, 0);
    do_access("sb",   2'd1, 3'd0, 32'h201, 32'h0000005A, 32'h0,
              '{1'b1, 32'h200, 4'b0010, 32'h5A5A5A5A}, 32'h0, 0);
    do_access("sw",   2'd3, 3'd0, 32'h300, 32'hCAFEF00D, 32'h0,
              '{1'b1, 32'h300, 4'b1111, 32'hCAFEF00D}, 32'h0, 0);
    do_access("st_wins", 2'd3, 3'd3, 32'h400, 32'h01020304, 32'h0,
              '{1'b1, 32'h400, 4'b1111, 32'h01020304}, 32'h0, 0);

    // Misaligned accesses: exception, no stall, no request
    @(posedge clk); #1;
    LdType = 3'd3; Addr = 32'h101;
    #2;
    check("mis_lw/exc",   MisalignExc, 1);
    check("mis_lw/stall", MemStall,    0);
    check("mis_lw/req",   DBus_Req,    0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #3;
      check("mis_lw/req_hold", DBus_Req,    0);
      check("mis_lw/exc_hold", MisalignExc, 1);
    end
    @(posedge clk); #1;
    clear_op(); StType = 2'd2; Addr = 32'h201;
    #2;
    check("mis_sh/exc", MisalignExc, 1);
    @(posedge clk); #1;
    clear_op(); LdType = 3'd5; Addr = 32'h003;
    #2;
    check("mis_lhu/exc", MisalignExc, 1);
    @(posedge clk); #1;
    clear_op(); StType = 2'd3; Addr = 32'h302;
    #2;
    check("mis_sw/exc", MisalignExc, 1);
    @(posedge clk); #1;
    clear_op();
    #2;
    check("mis_end/exc", MisalignExc, 0);
    @(posedge clk); #3;
    check("mis_end/req", DBus_Req, 0);

    // Timeout with Gnt held low, then late Gnt/RValid ignored
    @(posedge clk); #1;
    LdType = 3'd3; Addr = 32'h500;
    #2;
    check("to/c0_stall", MemStall, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #3;
      check("to/req",    DBus_Req, 1);
      check("to/buserr", BusErr,   (k == 4));
    end
    @(posedge clk); #1;
    DBus_Gnt = 1'b1; DBus_RValid = 1'b1; DBus_RData = 32'hFFFFFFFF;
    #2;
    check("to/done_lddata", LdData,   0);
    check("to/done_buserr", BusErr,   0);
    check("to/done_stall",  MemStall, 0);
    check("to/done_req",    DBus_Req, 0);
    @(posedge clk); #1;
    clear_op();
    #2;
    check("to/late_req",    DBus_Req, 0);
    check("to/late_lddata", LdData,   0);
    check("to/late_ldval",  LdValid,  0);
    check("to/late_stall",  MemStall, 0);
    @(posedge clk); #1;
    DBus_Gnt = 1'b0; DBus_RValid = 1'b0;
    #2;
    check("to/after_req",    DBus_Req, 0);
    check("to/after_lddata", LdData,   0);

    // ExtStall holds DONE for three cycles
    do_access("extstall", 2'd0, 3'd3, 32'h700, 32'h0, 32'h11223344,
              '{1'b0, 32'h700, 4'b1111, 32'h0}, 32'h11223344, 3);

    // Reset asserted while waiting for the response
    @(posedge clk); #1;
    LdType = 3'd3; Addr = 32'h604; StData = 32'h0;
    @(posedge clk); #3;
    check("rst/req", DBus_Req, 1);
    DBus_Gnt = 1'b1;
    @(posedge clk); #1;
    DBus_Gnt = 1'b0; rst = 1'b1;
    #2;
    check("rst/wait_req", DBus_Req, 0);
    @(posedge clk); #1;
    rst = 1'b0; clear_op();
    DBus_RValid = 1'b1; DBus_RData = 32'h12345678;
    #2;
    check_all_zero("rst_idle");
    @(posedge clk); #1;
    DBus_RValid = 1'b0;
    #2;
    check("rst/after_ldvalid", LdValid,  0);
    check("rst/after_lddata",  LdData,   0);
    check("rst/after_req",     DBus_Req, 0);
    check("rst/after_stall",   MemStall, 0);

    // Normal operation resumes after the mid-transaction reset
    do_access("lw_post_rst", 2'd0, 3'd3, 32'h800, 32'h0, 32'hA5A55A5A,
              '{1'b0, 32'h800, 4'b1111, 32'h0}, 32'hA5A55A5A, 0);

    check("scoreboard/bus_empty", exp_bus.size(), 0);
    check("scoreboard/ld_empty",  exp_ld.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
